// File: rtl/irst_inst_derandomizer.sv
// Fetch-path derandomizer: XORs each fetched word with the key it was stored under,
// tracking the in-flight re-randomization sweep and committing the new key at its end.
module irst_inst_derandomizer #(
  parameter int          PC_WIDTH  = 8,
  parameter logic [15:0] KEY_RESET = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         rand_inst,
  input  logic                key_load,
  input  logic [15:0]         key_in,
  input  logic                sweep_we,
  input  logic [PC_WIDTH-1:0] sweep_addr,
  output logic [15:0]         instruction,
  output logic                busy,
  output logic                sweep_done,
  output logic [3:0]          key_epoch,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [PC_WIDTH:0] PTR_END = {1'b1, {PC_WIDTH{1'b0}}};

  state_e              state_q, state_d;
  logic [15:0]         cur_key_q, cur_key_d;
  logic [15:0]         new_key_q, new_key_d;
  logic [PC_WIDTH:0]   sweep_ptr_q, sweep_ptr_d;
  logic [3:0]          key_epoch_q, key_epoch_d;
  logic                err_q, err_d;
  logic [15:0]         instruction_q, instruction_d;
  logic [15:0]         sel_key_s;

  // Key select: pre-increment pointer, so a same-cycle fetch/write of one word uses the old key
  always_comb begin
    sel_key_s = cur_key_q;
    if (state_q == ST_COMMIT) begin
      sel_key_s = new_key_q;
    end else if ((state_q == ST_SWEEP) && ({1'b0, pc} < sweep_ptr_q)) begin
      sel_key_s = new_key_q;
    end else begin
      sel_key_s = cur_key_q;
    end
  end

  // Next-state logic for sweep tracking, key commit, error flag and output register
  always_comb begin
    state_d       = state_q;
    cur_key_d     = cur_key_q;
    new_key_d     = new_key_q;
    sweep_ptr_d   = sweep_ptr_q;
    key_epoch_d   = key_epoch_q;
    err_d         = err_q;
    instruction_d = instruction_q;

    if (fetch_en) begin
      instruction_d = rand_inst ^ sel_key_s;
    end else begin
      instruction_d = instruction_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          new_key_d   = key_in;
          sweep_ptr_d = {(PC_WIDTH + 1){1'b0}};
          state_d     = ST_SWEEP;
        end else begin
          state_d = ST_IDLE;
        end
        if (sweep_we) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_SWEEP: begin
        if (sweep_we) begin
          if ({1'b0, sweep_addr} == {1'b0, sweep_ptr_q[PC_WIDTH-1:0]}) begin
            sweep_ptr_d = sweep_ptr_q + {{PC_WIDTH{1'b0}}, 1'b1};
            if (sweep_ptr_d == PTR_END) begin
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_SWEEP;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          sweep_ptr_d = sweep_ptr_q;
        end
        if (key_load) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
      end
      ST_COMMIT: begin
        cur_key_d   = new_key_q;
        key_epoch_d = key_epoch_q + 4'd1;
        state_d     = ST_IDLE;
        if (key_load) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_key_q     <= KEY_RESET;
      new_key_q     <= 16'h0000;
      sweep_ptr_q   <= {(PC_WIDTH + 1){1'b0}};
      key_epoch_q   <= 4'd0;
      err_q         <= 1'b0;
      instruction_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cur_key_q     <= cur_key_d;
      new_key_q     <= new_key_d;
      sweep_ptr_q   <= sweep_ptr_d;
      key_epoch_q   <= key_epoch_d;
      err_q         <= err_d;
      instruction_q <= instruction_d;
    end
  end

  assign instruction = instruction_q;
  assign busy        = (state_q != ST_IDLE);
  assign sweep_done  = (state_q == ST_COMMIT);
  assign key_epoch   = key_epoch_q;
  assign err         = err_q;

endmodule
